khazad_job_ctrl: RTL and testbench

PS-to-PL job controller for the KHAZAD core, successor to the single-block ECB controller. Accepts a toggle-handshake job request from the PS over AXI, runs a parametrised number of 64-bit blocks back-to-back in ECB or CBC mode, and issues per-block start, key-load and chaining controls to the cipher datapath. Supports an optional hang watchdog and reports completion and error status back to the PS and to indicator LEDs.

---
 rtl/khazad_job_ctrl.sv | 146 ++++++++++++++
 tb/tb_khazad_job_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/khazad_job_ctrl.sv
// rtl/khazad_job_ctrl.sv - PS-to-PL multi-block ECB/CBC job controller for the KHAZAD core
// Optional hang watchdog built when KHZ_CTRL_WATCHDOG_EN is defined.
module khazad_job_ctrl #(
  parameter int NBLK_W     = 8,
  parameter int WDOG_LIMIT = 1000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NBLK_W+4:0] ctrl_from_PS,
  input  logic              blk_rdy,
  input  logic              finish,
  output logic              start,
  output logic              load_key,
  output logic              iv_sel,
  output logic              chain_sel,
  output logic              enc_dec_SEL,
  output logic [NBLK_W-1:0] blk_idx,
  output logic              busy,
  output logic              err,
  output logic              ctrl_to_PS,
  output logic              RST_LED,
  output logic              encryption_LED,
  output logic              decryption_LED,
  output logic              PL_ready_LED,
  output logic              err_LED
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic              rst_i;
  logic              tog_l, only_l, cbc_l;
  logic [NBLK_W-1:0] cnt_l;
  logic              accept, launch, next_blk, done;
  logic              wdog_fire;

  assign rst_i = RST | ctrl_from_PS[4];

`ifdef KHZ_CTRL_WATCHDOG_EN
  logic [15:0] wdog_cnt;
  logic        err_q;

  always_ff @(posedge CLK) begin
    if (rst_i) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (launch)
        wdog_cnt <= '0;
      else if (state == S_WAIT && !finish)
        wdog_cnt <= wdog_cnt + 16'd1;
      if (wdog_fire)
        err_q <= 1'b1;
    end
  end

  // finish in the limit cycle takes precedence over the timeout
  assign wdog_fire = (state == S_WAIT) && !finish && (wdog_cnt == 16'(WDOG_LIMIT - 1));
  assign err       = err_q;
`else
  logic [15:0] unused_wdog_limit;
  assign unused_wdog_limit = 16'(WDOG_LIMIT);
  assign wdog_fire = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    launch    = 1'b0;
    next_blk  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if ((ctrl_from_PS[0] != ctrl_to_PS) && !err) begin
          accept    = 1'b1;
          state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (blk_rdy) begin
          launch    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (finish) begin
          if (blk_idx == cnt_l) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            next_blk  = 1'b1;
            state_nxt = S_ARM;
          end
        end else if (wdog_fire) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst_i) begin
      state       <= S_IDLE;
      start       <= 1'b0;
      load_key    <= 1'b0;
      iv_sel      <= 1'b0;
      chain_sel   <= 1'b0;
      ctrl_to_PS  <= 1'b0;
      blk_idx     <= '0;
      tog_l       <= 1'b0;
      enc_dec_SEL <= 1'b0;
      only_l      <= 1'b0;
      cbc_l       <= 1'b0;
      cnt_l       <= '0;
    end else begin
      state     <= state_nxt;
      start     <= launch;
      load_key  <= launch && (blk_idx == '0) && !only_l;
      iv_sel    <= launch && (blk_idx == '0) && cbc_l;
      chain_sel <= launch && (blk_idx != '0) && cbc_l;
      if (accept) begin
        tog_l       <= ctrl_from_PS[0];
        enc_dec_SEL <= ctrl_from_PS[1];
        only_l      <= ctrl_from_PS[2];
        cbc_l       <= ctrl_from_PS[3];
        cnt_l       <= ctrl_from_PS[NBLK_W+4:5];
        blk_idx     <= '0;
      end else if (next_blk) begin
        blk_idx <= blk_idx + 1'b1;
      end
      if (done)
        ctrl_to_PS <= tog_l;
    end
  end

  assign busy           = (state != S_IDLE);
  assign RST_LED        = rst_i;
  assign encryption_LED = enc_dec_SEL;
  assign decryption_LED = !enc_dec_SEL;
  assign PL_ready_LED   = !rst_i && !busy && !err;
  assign err_LED        = err;

endmodule

// File: tb/tb_khazad_job_ctrl.sv
// tb/tb_khazad_job_ctrl.sv - scoreboard testbench for khazad_job_ctrl
module tb_khazad_job_ctrl;

  localparam int NBLK_W = 8;

  typedef struct packed {
    logic [7:0] idx;
    logic       lk;
    logic       iv;
    logic       ch;
    logic       enc;
  } st_exp_t;

  typedef struct packed {
    logic val;
    logic er;
  } dn_exp_t;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NBLK_W+4:0] ctrl_from_PS;
  logic              blk_rdy, finish;
  logic              start, load_key, iv_sel, chain_sel, enc_dec_SEL;
  logic [NBLK_W-1:0] blk_idx;
  logic              busy, err, ctrl_to_PS;
  logic              RST_LED, encryption_LED, decryption_LED, PL_ready_LED, err_LED;

  st_exp_t start_q[$];
  dn_exp_t done_q[$];
  int      total  = 0;
  int      passed = 0;
  logic    prev_ctp = 1'b0;

  khazad_job_ctrl #(.NBLK_W(NBLK_W), .WDOG_LIMIT(1000)) dut (
    .CLK(CLK), .RST(RST), .ctrl_from_PS(ctrl_from_PS), .blk_rdy(blk_rdy), .finish(finish),
    .start(start), .load_key(load_key), .iv_sel(iv_sel), .chain_sel(chain_sel),
    .enc_dec_SEL(enc_dec_SEL), .blk_idx(blk_idx), .busy(busy), .err(err),
    .ctrl_to_PS(ctrl_to_PS), .RST_LED(RST_LED), .encryption_LED(encryption_LED),
    .decryption_LED(decryption_LED), .PL_ready_LED(PL_ready_LED), .err_LED(err_LED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [NBLK_W+4:0] mk(input logic tog, input logic enc, input logic only,
                                           input logic cbc, input logic srst, input logic [7:0] cnt);
    return {cnt, srst, cbc, only, enc, tog};
  endfunction

  function automatic st_exp_t se(input logic [7:0] idx, input logic lk, input logic iv,
                                 input logic ch, input logic enc);
    return {idx, lk, iv, ch, enc};
  endfunction

  function automatic dn_exp_t de(input logic val, input logic er);
    return {val, er};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_start(input int lim, output int n);
    n = 0;
    while (!start && n < lim) begin
      tick;
      n++;
    end
  endtask

  task automatic pulse_finish;
    finish = 1'b1;
    tick;
    finish = 1'b0;
  endtask

  // monitor: every start pulse and every ctrl_to_PS edge is matched against the queues
  always @(negedge CLK) begin
    st_exp_t s;
    dn_exp_t d;
    if (start) begin
      if (start_q.size() == 0) begin
        chk("unexpected_start", 32'd1, 32'd0);
      end else begin
        s = start_q.pop_front();
        chk("start_blk_idx", 32'(blk_idx), 32'(s.idx));
        chk("start_load_key", 32'(load_key), 32'(s.lk));
        chk("start_iv_sel", 32'(iv_sel), 32'(s.iv));
        chk("start_chain_sel", 32'(chain_sel), 32'(s.ch));
        chk("start_enc_dec", 32'(enc_dec_SEL), 32'(s.enc));
      end
    end
    if (ctrl_to_PS !== prev_ctp) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        d = done_q.pop_front();
        chk("done_ctrl_to_PS", 32'(ctrl_to_PS), 32'(d.val));
        chk("done_err", 32'(err), 32'(d.er));
        chk("done_busy", 32'(busy), 32'd0);
      end
      prev_ctp = ctrl_to_PS;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    RST = 1'b1; ctrl_from_PS = '0; blk_rdy = 1'b0; finish = 1'b0;
    repeat (3) tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_ctrl_to_PS", 32'(ctrl_to_PS), 32'd0);
    chk("rst_blk_idx", 32'(blk_idx), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_led", 32'(RST_LED), 32'd1);
    chk("rst_ready_led", 32'(PL_ready_LED), 32'd0);
    chk("rst_dec_led", 32'(decryption_LED), 32'd1);
    RST = 1'b0;
    tick;
    chk("idle_ready_led", 32'(PL_ready_LED), 32'd1);
    chk("idle_rst_led", 32'(RST_LED), 32'd0);

    // single ECB block, fresh key, encrypt
    start_q.push_back(se(8'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    done_q.push_back(de(1'b1, 1'b0));
    ctrl_from_PS = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    blk_rdy = 1'b1;
    wait_start(10, n);
    chk("t1_start_latency", 32'(n), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_enc_led", 32'(encryption_LED), 32'd1);
    repeat (20) tick;
    pulse_finish;
    chk("t1_ctrl_to_PS", 32'(ctrl_to_PS), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // four-block CBC decrypt with key reuse; config flipped during block 1
    start_q.push_back(se(8'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int b = 1; b < 4; b++) start_q.push_back(se(8'(b), 1'b0, 1'b0, 1'b1, 1'b0));
    done_q.push_back(de(1'b0, 1'b0));
    ctrl_from_PS = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
    for (int b = 0; b < 4; b++) begin
      wait_start(10, n);
      chk("t2_start_latency", 32'(n), (b == 0) ? 32'd2 : 32'd1);
      if (b == 1) ctrl_from_PS = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      repeat (3) tick;
      chk("t2_latched_enc", 32'(enc_dec_SEL), 32'd0);
      pulse_finish;
      if (b < 3) chk("t2_busy_mid", 32'(busy), 32'd1);
    end
    chk("t2_ctrl_to_PS", 32'(ctrl_to_PS), 32'd0);
    chk("t2_busy_end", 32'(busy), 32'd0);

    // ARM held by blk_rdy=0 with a stray finish
    blk_rdy = 1'b0;
    start_q.push_back(se(8'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    done_q.push_back(de(1'b1, 1'b0));
    ctrl_from_PS = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (start) seen++;
      finish = (i == 20);
    end
    finish = 1'b0;
    chk("t3_no_start", 32'(seen), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_no_err", 32'(err), 32'd0);
    blk_rdy = 1'b1;
    wait_start(5, n);
    chk("t3_start_after_rdy", 32'(n), 32'd1);
    pulse_finish;
    chk("t3_ctrl_to_PS", 32'(ctrl_to_PS), 32'd1);

    // soft reset during WAIT of block 2 of 4
    start_q.push_back(se(8'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    start_q.push_back(se(8'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    start_q.push_back(se(8'd2, 1'b0, 1'b0, 1'b0, 1'b1));
    done_q.push_back(de(1'b0, 1'b0));
    ctrl_from_PS = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    for (int b = 0; b < 3; b++) begin
      wait_start(10, n);
      chk("t5_start_latency", 32'(n), (b == 0) ? 32'd2 : 32'd1);
      if (b < 2) begin
        repeat (2) tick;
        pulse_finish;
      end
    end
    tick;
    ctrl_from_PS = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3);
    #1;
    chk("t5_rst_led", 32'(RST_LED), 32'd1);
    chk("t5_ready_led", 32'(PL_ready_LED), 32'd0);
    tick;
    ctrl_from_PS = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_blk_idx", 32'(blk_idx), 32'd0);
    chk("t5_ctrl_to_PS", 32'(ctrl_to_PS), 32'd0);
    chk("t5_enc_cleared", 32'(enc_dec_SEL), 32'd0);
    pulse_finish;
    repeat (5) tick;
    chk("t5_busy_after_finish", 32'(busy), 32'd0);
    chk("t5_ctp_after_finish", 32'(ctrl_to_PS), 32'd0);

`ifdef KHZ_CTRL_WATCHDOG_EN
    // watchdog timeout then finish exactly at the limit
    start_q.push_back(se(8'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    done_q.push_back(de(1'b1, 1'b1));
    ctrl_from_PS = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_start(10, n);
    chk("t4_start_latency", 32'(n), 32'd2);
    repeat (999) tick;
    chk("t4_err_before", 32'(err), 32'd0);
    chk("t4_busy_before", 32'(busy), 32'd1);
    tick;
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_ctrl_to_PS", 32'(ctrl_to_PS), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_err_led", 32'(err_LED), 32'd1);
    chk("t4_ready_led", 32'(PL_ready_LED), 32'd0);
    ctrl_from_PS = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    repeat (10) tick;
    chk("t4_blocked_busy", 32'(busy), 32'd0);
    chk("t4_blocked_ctp", 32'(ctrl_to_PS), 32'd1);
    done_q.push_back(de(1'b0, 1'b0));
    RST = 1'b1;
    tick;
    RST = 1'b0;
    tick;
    chk("t4_err_cleared", 32'(err), 32'd0);
    start_q.push_back(se(8'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    done_q.push_back(de(1'b1, 1'b0));
    ctrl_from_PS = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_start(10, n);
    chk("t4b_start_latency", 32'(n), 32'd2);
    repeat (999) tick;
    pulse_finish;
    chk("t4b_err", 32'(err), 32'd0);
    chk("t4b_ctrl_to_PS", 32'(ctrl_to_PS), 32'd1);
    chk("t4b_busy", 32'(busy), 32'd0);
`else
    // without the watchdog a long WAIT never errors
    start_q.push_back(se(8'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    done_q.push_back(de(1'b1, 1'b0));
    ctrl_from_PS = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    wait_start(10, n);
    chk("t4_start_latency", 32'(n), 32'd2);
    repeat (1100) tick;
    chk("t4_no_err", 32'(err), 32'd0);
    chk("t4_still_busy", 32'(busy), 32'd1);
    pulse_finish;
    chk("t4_ctrl_to_PS", 32'(ctrl_to_PS), 32'd1);
`endif

    repeat (3) tick;
    chk("start_q_drained", 32'(start_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
